// File: rtl/lcd_lines_to_hd44780.sv
// Drives an HD44780-class LCD in 8-bit write-only mode from two 16-character row buffers.
// Optional LCD_FRAME_SNAPSHOT_EN latches both rows once per frame so a frame never tears.
module lcd_lines_to_hd44780 #(
  parameter int unsigned POWERUP_CYCLES = 2_000_000,
  parameter int unsigned SETUP_CYCLES   = 5,
  parameter int unsigned E_PULSE_CYCLES = 25,
  parameter int unsigned CMD_CYCLES     = 5_000,
  parameter int unsigned CLEAR_CYCLES   = 200_000
) (
  input  logic         Clock_100MHz,
  input  logic         Reset_n,
  input  logic [127:0] Line_1,
  input  logic [127:0] Line_2,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_E,
  output logic [7:0]   LCD_DB,
  output logic         Init_done,
  output logic         Frame_done
);

  localparam int unsigned CMD_PERIOD = SETUP_CYCLES + E_PULSE_CYCLES + CMD_CYCLES;
  localparam int unsigned CLR_PERIOD = SETUP_CYCLES + E_PULSE_CYCLES + CLEAR_CYCLES;
  localparam int unsigned MAX_CNT    = (POWERUP_CYCLES > CLR_PERIOD) ? POWERUP_CYCLES : CLR_PERIOD;
  localparam int unsigned CW         = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    ST_POWERUP = 2'd0,
    ST_INIT    = 2'd1,
    ST_FRAME   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic          rs_q, rs_d;
  logic [7:0]    db_q, db_d;
  logic          e_q, e_d;
  logic          init_done_q, init_done_d;
  logic          frame_done_q, frame_done_d;
  logic          wait_end_s;
  logic          snap_s;
  logic [127:0]  l1_src_s, l2_src_s;

  function automatic logic [7:0] init_cmd(input logic [5:0] k);
    case (k)
      6'd0:    return 8'h38;
      6'd1:    return 8'h0C;
      6'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Non-printable bytes would show as garbage glyphs, so they become blanks.
  function automatic logic [7:0] filter_char(input logic [7:0] c);
    if ((c < 8'h20) || (c > 8'h7E)) return 8'h20;
    else return c;
  endfunction

  function automatic logic [7:0] line_char(input logic [127:0] line, input logic [5:0] k);
    logic [127:0] sh;
    sh = line << (7'(k) << 3);
    return sh[127:120];
  endfunction

  // Frame layout: 0x80, 16 chars of row 1, 0xC0, 16 chars of row 2; returns {rs, db}.
  function automatic logic [8:0] frame_byte(input logic [5:0] k, input logic [127:0] l1,
                                            input logic [127:0] l2);
    if (k == 6'd0) return {1'b0, 8'h80};
    else if (k <= 6'd16) return {1'b1, filter_char(line_char(l1, k - 6'd1))};
    else if (k == 6'd17) return {1'b0, 8'hC0};
    else return {1'b1, filter_char(line_char(l2, k - 6'd18))};
  endfunction

`ifdef LCD_FRAME_SNAPSHOT_EN
  logic [255:0] shadow_q, shadow_d;
  assign l1_src_s = shadow_q[255:128];
  assign l2_src_s = shadow_q[127:0];

  // Rows are frozen on the cycle the frame's 0x80 transfer starts.
  always_comb begin
    if (snap_s) shadow_d = {Line_1, Line_2};
    else shadow_d = shadow_q;
  end

  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) shadow_q <= 256'd0;
    else shadow_q <= shadow_d;
  end
`else
  assign l1_src_s = Line_1;
  assign l2_src_s = Line_2;
`endif

  // Sequencer next state: powerup wait, then one transfer period per byte.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    idx_d        = idx_q;
    rs_d         = rs_q;
    db_d         = db_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    snap_s       = 1'b0;
    if (!rs_q && (db_q == 8'h01)) wait_end_s = (cnt_q == CW'(CLR_PERIOD - 1));
    else wait_end_s = (cnt_q == CW'(CMD_PERIOD - 1));
    case (state_q)
      ST_POWERUP: begin
        if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          idx_d   = 6'd0;
          rs_d    = 1'b0;
          db_d    = init_cmd(6'd0);
        end else begin
          state_d = ST_POWERUP;
        end
      end
      ST_INIT: begin
        if (wait_end_s) begin
          cnt_d = '0;
          rs_d  = 1'b0;
          if (idx_q == 6'd3) begin
            state_d     = ST_FRAME;
            idx_d       = 6'd0;
            db_d        = 8'h80;
            init_done_d = 1'b1;
            snap_s      = 1'b1;
          end else begin
            idx_d = idx_q + 6'd1;
            db_d  = init_cmd(idx_q + 6'd1);
          end
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_FRAME: begin
        if (wait_end_s) begin
          cnt_d = '0;
          if (idx_q == 6'd33) begin
            idx_d        = 6'd0;
            rs_d         = 1'b0;
            db_d         = 8'h80;
            frame_done_d = 1'b1;
            snap_s       = 1'b1;
          end else begin
            idx_d         = idx_q + 6'd1;
            {rs_d, db_d}  = frame_byte(idx_q + 6'd1, l1_src_s, l2_src_s);
          end
        end else begin
          state_d = ST_FRAME;
        end
      end
      default: begin
        state_d = ST_POWERUP;
        cnt_d   = '0;
      end
    endcase
    if ((state_d != ST_POWERUP) && (cnt_d >= CW'(SETUP_CYCLES)) &&
        (cnt_d < CW'(SETUP_CYCLES + E_PULSE_CYCLES))) e_d = 1'b1;
    else e_d = 1'b0;
  end

  // State and registered LCD pins.
  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_POWERUP;
      cnt_q        <= '0;
      idx_q        <= 6'd0;
      rs_q         <= 1'b0;
      db_q         <= 8'h00;
      e_q          <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rs_q         <= rs_d;
      db_q         <= db_d;
      e_q          <= e_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_E      = e_q;
  assign LCD_DB     = db_q;
  assign Init_done  = init_done_q;
  assign Frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_lines_to_hd44780.sv
// Directed bench for lcd_lines_to_hd44780 with shortened timing (period 26 clks, clear 56 clks).
module tb_lcd_lines_to_hd44780;

  logic         clk;
  logic         Reset_n;
  logic [127:0] Line_1, Line_2;
  logic         LCD_RS, LCD_RW, LCD_E, Init_done, Frame_done;
  logic [7:0]   LCD_DB;

  lcd_lines_to_hd44780 #(
    .POWERUP_CYCLES(100), .SETUP_CYCLES(2), .E_PULSE_CYCLES(4),
    .CMD_CYCLES(20), .CLEAR_CYCLES(50)
  ) dut (
    .Clock_100MHz(clk), .Reset_n(Reset_n), .Line_1(Line_1), .Line_2(Line_2),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_DB(LCD_DB),
    .Init_done(Init_done), .Frame_done(Frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] l1;
    logic [127:0] l2;
    int           chg_at;
    logic [127:0] chg_l1;
    logic [127:0] exp1;
    logic [127:0] exp2;
  } vec_t;

  vec_t       vecs[4];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         fd_count = 0;
  int         id_rise_cyc = -1;
  logic       e_prev = 1'b0, e_rise = 1'b0, id_prev = 1'b0;
  logic       got_rs[34];
  logic [7:0] got_db[34];
  int         got_cyc[34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    e_rise  = LCD_E && !e_prev;
    e_prev  = LCD_E;
    if (Init_done && !id_prev) id_rise_cyc = cyc;
    id_prev = Init_done;
    if (Frame_done) begin
      fd_count++;
      chk("frame_done_with_0x80", {23'd0, LCD_RS, LCD_DB}, 32'h080);
    end
  endtask

  task automatic get_strobe(output logic rs, output logic [7:0] db, output int c);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!e_rise && n < 200);
    if (!e_rise) chk("strobe_timeout", 32'd0, 32'd1);
    rs = LCD_RS;
    db = LCD_DB;
    c  = cyc;
  endtask

  task automatic check_powerup();
    logic bad = 1'b0;
    logic exp_e[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 100; i++) begin
      tick();
      if (LCD_E || Init_done) bad = 1'b1;
    end
    chk("powerup_e_low", {31'd0, bad}, 32'd0);
    chk("first_cmd_db", {24'd0, LCD_DB}, 32'h38);
    chk("first_cmd_rs", {31'd0, LCD_RS}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("first_e_cycle_%0d", 101 + i), {31'd0, LCD_E}, {31'd0, exp_e[i]});
    end
  endtask

  task automatic check_init();
    logic [7:0] exp_db[3]  = '{8'h0C, 8'h06, 8'h01};
    int         exp_cyc[3] = '{128, 154, 180};
    logic rs;
    logic [7:0] db;
    int c;
    for (int i = 0; i < 3; i++) begin
      get_strobe(rs, db, c);
      chk($sformatf("init_db_%0d", i + 1), {24'd0, db}, {24'd0, exp_db[i]});
      chk($sformatf("init_rs_%0d", i + 1), {31'd0, rs}, 32'd0);
      chk($sformatf("init_cyc_%0d", i + 1), c, exp_cyc[i]);
    end
    chk("init_done_before_clear_end", {31'd0, Init_done}, 32'd0);
  endtask

  initial begin
    logic rs;
    logic [7:0] db;
    int c, n;
    logic spacing_bad;

    vecs[0] = '{"HELLO           ", "AAAAAAAAAAAAAAAA", -1, 128'd0,
                "HELLO           ", "AAAAAAAAAAAAAAAA"};
    vecs[1] = '{{"Key", 8'h1F, 8'h7E, 8'h7F, 8'hFF, 8'h20, "z09!?@[]"},
                {8'h0A, "BCDEFGHIJKLMNO", 8'h7F}, -1, 128'd0,
                {"Key", 8'h20, 8'h7E, 8'h20, 8'h20, 8'h20, "z09!?@[]"},
                " BCDEFGHIJKLMNO "};
`ifdef LCD_FRAME_SNAPSHOT_EN
    vecs[2] = '{"AAAAAAAAAAAAAAAA", "Row two constant", 8, "BBBBBBBBBBBBBBBB",
                "AAAAAAAAAAAAAAAA", "Row two constant"};
`else
    vecs[2] = '{"AAAAAAAAAAAAAAAA", "Row two constant", 8, "BBBBBBBBBBBBBBBB",
                "AAAAAAAABBBBBBBB", "Row two constant"};
`endif
    vecs[3] = '{"0123456789ABCDEF", "Frame four ends!", -1, 128'd0,
                "0123456789ABCDEF", "Frame four ends!"};

    Line_1  = vecs[0].l1;
    Line_2  = vecs[0].l2;
    Reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rs", {31'd0, LCD_RS}, 32'd0);
    chk("rst_rw", {31'd0, LCD_RW}, 32'd0);
    chk("rst_e", {31'd0, LCD_E}, 32'd0);
    chk("rst_db", {24'd0, LCD_DB}, 32'd0);
    chk("rst_init_done", {31'd0, Init_done}, 32'd0);
    chk("rst_frame_done", {31'd0, Frame_done}, 32'd0);

    @(negedge clk);
    Reset_n = 1'b1;
    cyc = 0;
    check_powerup();
    check_init();

    for (int v = 0; v < 4; v++) begin
      Line_1 = vecs[v].l1;
      Line_2 = vecs[v].l2;
      for (int k = 0; k < 34; k++) begin
        get_strobe(rs, db, c);
        got_rs[k] = rs;
        got_db[k] = db;
        got_cyc[k] = c;
        if (k == 0) chk($sformatf("frame%0d_done_count", v), fd_count, v);
        if (k == vecs[v].chg_at) Line_1 = vecs[v].chg_l1;
      end
      if (v == 0) begin
        chk("init_done_rise_cycle", id_rise_cyc, 234);
        chk("first_0x80_strobe_cycle", got_cyc[0], 236);
      end
      spacing_bad = 1'b0;
      for (int k = 0; k < 33; k++)
        if (got_cyc[k + 1] - got_cyc[k] != 26) spacing_bad = 1'b1;
      chk($sformatf("frame%0d_spacing", v), {31'd0, spacing_bad}, 32'd0);
      for (int k = 0; k < 34; k++) begin
        logic [8:0] exp;
        logic [127:0] row;
        if (k == 0) exp = {1'b0, 8'h80};
        else if (k == 17) exp = {1'b0, 8'hC0};
        else begin
          row = (k < 17) ? vecs[v].exp1 : vecs[v].exp2;
          n   = (k < 17) ? k - 1 : k - 18;
          exp = {1'b1, row[127 - 8 * n -: 8]};
        end
        chk($sformatf("frame%0d_byte%0d", v, k), {23'd0, got_rs[k], got_db[k]}, {23'd0, exp});
      end
    end

    n = 0;
    while (!LCD_E && n < 100) begin
      tick();
      n++;
    end
    chk("e_high_before_reset", {31'd0, LCD_E}, 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("midreset_e", {31'd0, LCD_E}, 32'd0);
    chk("midreset_init_done", {31'd0, Init_done}, 32'd0);
    chk("midreset_db", {24'd0, LCD_DB}, 32'd0);
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
    cyc = 0;
    e_prev = 1'b0;
    id_prev = 1'b0;
    check_powerup();
    check_init();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
